// File: rtl/pdm_cic_decim.sv
// Single-channel PDM to PCM decimator: four integrators at the input rate, and a time-shared comb chain at the output rate.
// Optional DC blocker on the output path is enabled by defining PDM_CIC_DCBLOCK_EN.
module pdm_cic_decim #(
   parameter int DECIM_LOG2 = 6,
   parameter int OUT_BITS   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_data,
   input  logic                sync,
   output logic [OUT_BITS-1:0] out_data,
   output logic                out_valid
);

   localparam int W     = 4*DECIM_LOG2 + 2;
   localparam int SHIFT = W - 1 - OUT_BITS;

   localparam logic signed [W-1:0] X_POS   = W'(1);
   localparam logic signed [W-1:0] X_NEG   = '1;
   localparam logic signed [W-1:0] OUT_MAX = {{(W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [W-1:0] OUT_MIN = {{(W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
   localparam logic [DECIM_LOG2-1:0] DCNT_MAX = '1;
   localparam logic [DECIM_LOG2-1:0] DCNT_ONE = DECIM_LOG2'(1);

`ifdef PDM_CIC_DCBLOCK_EN
   // Internal width grows with OUT_BITS so wide outputs still have two bits of headroom.
   localparam int DCB_W = (OUT_BITS + 2 > 18) ? OUT_BITS + 2 : 18;
   localparam int TW    = DCB_W + 2;
   localparam logic signed [TW-1:0]    DCB_MAX  = {{3{1'b0}}, {(DCB_W-1){1'b1}}};
   localparam logic signed [TW-1:0]    DCB_MIN  = {{3{1'b1}}, {(DCB_W-1){1'b0}}};
   localparam logic signed [DCB_W-1:0] DOUT_MAX = {{(DCB_W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [DCB_W-1:0] DOUT_MIN = {{(DCB_W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
`endif

   typedef enum logic [2:0] {S_IDLE, S_C0, S_C1, S_C2, S_C3, S_DCB, S_OUT} state_t;

   function automatic logic signed [OUT_BITS-1:0] sat_out(input logic signed [W-1:0] v);
      if (v > OUT_MAX)      return OUT_MAX[OUT_BITS-1:0];
      else if (v < OUT_MIN) return OUT_MIN[OUT_BITS-1:0];
      else                  return v[OUT_BITS-1:0];
   endfunction

   function automatic logic signed [OUT_BITS-1:0] scale_sat(input logic signed [W-1:0] v);
      logic signed [W-1:0] sh;
      sh = v >>> SHIFT;
      return sat_out(sh);
   endfunction

`ifdef PDM_CIC_DCBLOCK_EN
   function automatic logic signed [DCB_W-1:0] sat_dcb(input logic signed [TW-1:0] v);
      if (v > DCB_MAX)      return DCB_MAX[DCB_W-1:0];
      else if (v < DCB_MIN) return DCB_MIN[DCB_W-1:0];
      else                  return v[DCB_W-1:0];
   endfunction

   function automatic logic signed [OUT_BITS-1:0] sat_dcb_out(input logic signed [DCB_W-1:0] v);
      if (v > DOUT_MAX)      return DOUT_MAX[OUT_BITS-1:0];
      else if (v < DOUT_MIN) return DOUT_MIN[OUT_BITS-1:0];
      else                   return v[OUT_BITS-1:0];
   endfunction
`endif

   state_t state_q, state_d;
   logic signed [W-1:0] i0_q, i0_d, i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic signed [W-1:0] i0_n, i1_n, i2_n, i3_n, x;
   logic signed [W-1:0] cin_q, cin_d, acc_q, acc_d;
   logic signed [W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic signed [W-1:0] sub_a, sub_b, diff;
   logic [DECIM_LOG2-1:0] dcnt_q, dcnt_d;
   logic [OUT_BITS-1:0]   out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  frame_done;
`ifdef PDM_CIC_DCBLOCK_EN
   logic signed [OUT_BITS-1:0] sp_q, sp_d, s_cur;
   logic signed [DCB_W-1:0]    yp_q, yp_d;
   logic signed [TW-1:0]       t_sum;
`endif

   always_comb begin
      i0_d        = i0_q;
      i1_d        = i1_q;
      i2_d        = i2_q;
      i3_d        = i3_q;
      dcnt_d      = dcnt_q;
      cin_d       = cin_q;
      acc_d       = acc_q;
      d0_d        = d0_q;
      d1_d        = d1_q;
      d2_d        = d2_q;
      d3_d        = d3_q;
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
`ifdef PDM_CIC_DCBLOCK_EN
      sp_d  = sp_q;
      yp_d  = yp_q;
      s_cur = '0;
      t_sum = '0;
`endif

      x    = in_data ? X_POS : X_NEG;
      i0_n = i0_q + x;
      i1_n = i1_q + i0_n;
      i2_n = i2_q + i1_n;
      i3_n = i3_q + i2_n;

      // A sync coinciding with an input makes that input the first of a new frame.
      frame_done = in_valid && !sync && (dcnt_q == DCNT_MAX);

      if (in_valid) begin
         i0_d   = i0_n;
         i1_d   = i1_n;
         i2_d   = i2_n;
         i3_d   = i3_n;
         dcnt_d = sync ? DCNT_ONE : dcnt_q + 1'b1;
      end else if (sync) begin
         dcnt_d = '0;
      end

      sub_a = (state_q == S_C0) ? cin_q : acc_q;
      case (state_q)
         S_C0:    sub_b = d0_q;
         S_C1:    sub_b = d1_q;
         S_C2:    sub_b = d2_q;
         S_C3:    sub_b = d3_q;
         default: sub_b = '0;
      endcase
      diff = sub_a - sub_b;

      case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_C0: begin
            d0_d    = sub_a;
            acc_d   = diff;
            state_d = S_C1;
         end
         S_C1: begin
            d1_d    = sub_a;
            acc_d   = diff;
            state_d = S_C2;
         end
         S_C2: begin
            d2_d    = sub_a;
            acc_d   = diff;
            state_d = S_C3;
         end
         S_C3: begin
            d3_d    = sub_a;
            acc_d   = diff;
`ifdef PDM_CIC_DCBLOCK_EN
            state_d = S_DCB;
`else
            state_d = S_OUT;
`endif
         end
`ifdef PDM_CIC_DCBLOCK_EN
         S_DCB: begin
            s_cur   = scale_sat(acc_q);
            t_sum   = TW'(s_cur) - TW'(sp_q) + TW'(yp_q) - TW'(yp_q >>> 8);
            sp_d    = s_cur;
            yp_d    = sat_dcb(t_sum);
            state_d = S_OUT;
         end
`endif
         S_OUT: begin
`ifdef PDM_CIC_DCBLOCK_EN
            out_data_d = sat_dcb_out(yp_q);
`else
            out_data_d = scale_sat(acc_q);
`endif
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (frame_done) begin
         cin_d   = i3_n;
         state_d = S_C0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i0_q        <= '0;
         i1_q        <= '0;
         i2_q        <= '0;
         i3_q        <= '0;
         dcnt_q      <= '0;
         cin_q       <= '0;
         acc_q       <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         d3_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef PDM_CIC_DCBLOCK_EN
         sp_q        <= '0;
         yp_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         i0_q        <= i0_d;
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         i3_q        <= i3_d;
         dcnt_q      <= dcnt_d;
         cin_q       <= cin_d;
         acc_q       <= acc_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         d3_q        <= d3_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef PDM_CIC_DCBLOCK_EN
         sp_q        <= sp_d;
         yp_q        <= yp_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Bench for pdm_cic_decim: outputs are predicted by convolving the input history with the CIC impulse response.
module tb_pdm_cic_decim;

   localparam int DECIM_LOG2 = 6;
   localparam int OUT_BITS   = 16;
   localparam int R          = 64;
   localparam int SHIFT      = 9;
   localparam int HL         = 4*R - 3;
`ifdef PDM_CIC_DCBLOCK_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 6;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_data = 1'b0;
   logic sync = 1'b0;
   logic [OUT_BITS-1:0] out_data;
   logic out_valid;

   pdm_cic_decim #(.DECIM_LOG2(DECIM_LOG2), .OUT_BITS(OUT_BITS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sync(sync),
      .out_data(out_data), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct { int due; int val; } pend_t;

   int    h [HL];
   int    hist [$];
   pend_t pend [$];
   int    ecount = 0;
   int    mcnt = 0;
   logic  exp_valid = 1'b0;
   int    exp_data = 0;
   int    dsp = 0;
   int    dyp = 0;
   int    n_checks = 0;
   int    n_fails = 0;
   int    lit_seq = 0;
   int    lit_done = 0;
   string lit_name;
   int    lit_got, lit_exp;

   function automatic longint sat(input longint v, input int bits);
      longint maxv;
      maxv = (longint'(1) <<< (bits - 1)) - 1;
      if (v > maxv) return maxv;
      if (v < -maxv - 1) return -maxv - 1;
      return v;
   endfunction

   function automatic int cic_out();
      longint acc;
      int idx;
      acc = 0;
      for (int k = 0; k < HL; k++) begin
         idx = hist.size() - 1 - k;
         if (idx >= 0) acc += longint'(h[k]) * longint'(hist[idx]);
      end
      return int'(sat(acc >>> SHIFT, OUT_BITS));
   endfunction

   // Reference model: tracks frame boundaries and schedules each predicted sample.
   initial begin
      int v;
      forever begin
         @(posedge clk);
         ecount++;
         if (rst) begin
            hist.delete();
            pend.delete();
            mcnt = 0;
            exp_valid = 1'b0;
            exp_data = 0;
            dsp = 0;
            dyp = 0;
         end else begin
            if (in_valid) begin
               hist.push_back(in_data ? 1 : -1);
               if (sync) mcnt = 1;
               else begin
                  if (mcnt == R - 1) begin
                     v = cic_out();
`ifdef PDM_CIC_DCBLOCK_EN
                     begin
                        int y;
                        y = v - dsp + dyp - (dyp >>> 8);
                        dsp = v;
                        dyp = int'(sat(y, 18));
                        v = int'(sat(dyp, OUT_BITS));
                     end
`endif
                     pend.push_back('{due: ecount + LAT - 1, val: v});
                  end
                  mcnt = (mcnt + 1) % R;
               end
            end else if (sync) begin
               mcnt = 0;
            end
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == ecount) begin
               exp_valid = 1'b1;
               exp_data = pend[0].val;
               void'(pend.pop_front());
            end
         end
      end
   end

   initial begin
      int got;
      forever begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== exp_valid) begin
            n_fails++;
            if (n_fails <= 30) $display("FAIL out_valid @cycle %0d: got %b, required %b", ecount, out_valid, exp_valid);
         end
         got = int'($signed(out_data));
         n_checks++;
         if ($isunknown(out_data) || got != exp_data) begin
            n_fails++;
            if (n_fails <= 30) $display("FAIL out_data @cycle %0d: got %0d, required %0d", ecount, got, exp_data);
         end
         if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            n_checks++;
            if (lit_got != lit_exp) begin
               n_fails++;
               $display("FAIL %s: got %0d, required %0d", lit_name, lit_got, lit_exp);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input int got, input int expv);
      lit_name = name;
      lit_got = got;
      lit_exp = expv;
      lit_seq++;
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic d, input logic s, input int gap);
      in_valid = 1'b1;
      in_data = d;
      sync = s;
      tick();
      in_valid = 1'b0;
      sync = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   function automatic logic patt(input int i);
      int t;
      t = (i * i + 3 * i) >> 2;
      return t[0];
   endfunction

   initial begin
      int tmp [HL];
      int len, sum, n;
      for (int i = 0; i < HL; i++) h[i] = (i < R) ? 1 : 0;
      len = R;
      repeat (3) begin
         for (int i = 0; i < HL; i++) tmp[i] = 0;
         for (int i = 0; i < len; i++)
            for (int j = 0; j < R; j++) tmp[i + j] += h[i];
         len += R - 1;
         for (int i = 0; i < HL; i++) h[i] = tmp[i];
      end
      sum = 0;
      for (int i = 0; i < HL; i++) sum += h[i];

      do_reset();
      lit("model_h_sum", sum, 16777216);
      lit("model_h1", h[1], 4);
      lit("model_h2", h[2], 10);
      lit("model_h_last", h[HL-1], 1);
      lit("model_fullscale", int'(sat(longint'(16777216) >>> SHIFT, OUT_BITS)), 32767);
      lit("reset_data", int'($signed(out_data)), 0);
      lit("reset_valid", int'(out_valid), 0);

      repeat (6 * R) send(1'b1, 1'b0, 32);
`ifndef PDM_CIC_DCBLOCK_EN
      lit("ones_saturated", int'($signed(out_data)), 32767);
`endif

      do_reset();
      repeat (6 * R) send(1'b0, 1'b0, 8);
`ifndef PDM_CIC_DCBLOCK_EN
      lit("zeros_negfull", int'($signed(out_data)), -32768);
`endif

      do_reset();
      for (int i = 0; i < 6 * R; i++) send((i % 2) == 0, 1'b0, 8);
      lit("alternating_zero", int'($signed(out_data)), 0);

      do_reset();
      repeat (5 * R + 20) send(1'b1, 1'b0, 8);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      repeat (7) tick();
      repeat (R - 1) send(1'b1, 1'b0, 8);
      send(1'b1, 1'b0, 1);
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      lit("latency", n, LAT);
      tick();
      lit("valid_width", int'(out_valid), 0);
      repeat (8) tick();
`ifndef PDM_CIC_DCBLOCK_EN
      lit("sync_ones", int'($signed(out_data)), 32767);
`endif
      repeat (10) send(1'b1, 1'b0, 8);
      send(1'b1, 1'b1, 8);
      repeat (R - 1) send(1'b1, 1'b0, 8);
`ifndef PDM_CIC_DCBLOCK_EN
      lit("sync_coincident_ones", int'($signed(out_data)), 32767);
`endif

      do_reset();
      for (int i = 0; i < 6 * R - 1; i++) send(patt(i), 1'b0, 8);
      send(patt(6 * R - 1), 1'b0, 1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (12) tick();
      lit("abort_data", int'($signed(out_data)), 0);
      for (int i = 0; i < 5 * R; i++) send(patt(i), 1'b0, 8);
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pdm_cic_decim.md
Name: pdm_cic_decim

Overview:
- Downstream consumer of the per-channel PDM bitstream produced by the side-sync / sum stage.
  - Takes one PDM bit per `in_valid` strobe.
  - Runs a 4-stage CIC decimator and emits signed PCM words with a one-cycle `out_valid` strobe.
- One instance per channel.
- Output feeds the PCM/serialiser stage.

Parameters:
- DECIM_LOG2, 6, log2 of decimation ratio (R = 2^DECIM_LOG2 = 64); legal range 2..8.
- OUT_BITS, 16, signed PCM output width; must satisfy OUT_BITS <= 4*DECIM_LOG2+1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  single-cycle strobe; `in_data` is sampled only when high.
- in_data  input  1  PDM bit; 1 maps to +1, 0 maps to -1.
- sync  input  1  single-cycle; realigns the decimation frame.
- out_data  output  OUT_BITS  signed PCM sample.
- out_valid  output  1  single-cycle strobe; `out_data` is stable from this cycle until the next strobe.

Behaviour:
- Widths
  - Internal word width W = 4*DECIM_LOG2 + 2 (26 at default), two's complement.
  - Integrators and comb stages wrap modulo 2^W; no saturation inside.
- Integrators I0..I3
  - Update only on cycles with `in_valid`=1:
    - I0 += x (x = +1 or -1, sign-extended)
    - I1 += I0_new
    - I2 += I1_new
    - I3 += I2_new
  - The chain is fully combinational within one cycle.
- Decimation counter `dcnt` (DECIM_LOG2 bits)
  - Increments on each `in_valid`.
  - When `in_valid` arrives with `dcnt` = R-1, I3_new is latched into the comb input register and the comb FSM is started.
  - `dcnt` wraps to 0.
- sync
  - Sets `dcnt` to 0 without touching integrators or combs.
  - If `sync` and `in_valid` occur in the same cycle, the input is consumed and `dcnt` becomes 1.
- Comb FSM states: IDLE -> C0 -> C1 -> C2 -> C3 -> OUT -> IDLE.
  - State Ck computes y_k = y_(k-1) - D_k (y_-1 = latched I3), then D_k <= y_(k-1).
  - One stage per cycle, using a single shared subtractor.
  - OUT state scales and saturates (see below), drives `out_data`, pulses `out_valid`.
- Latency
  - `out_valid` goes high exactly 6 clk cycles after the frame-completing `in_valid` cycle.
  - `in_valid` spacing is guaranteed >= 8 clk by upstream; a frame completion while the FSM is not IDLE is undefined (not checked).
- Integrators keep running while the comb FSM is busy.
- Scaling
  - Comb result C is in [-2^(W-2), +2^(W-2)].
  - out = C >>> (W-1-OUT_BITS), arithmetic shift (9 at default).
  - Saturate to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]; only the +full-scale case clips (+32768 becomes 32767).
- Reset (synchronous, active-high)
  - Integrators, comb delays, `dcnt` and the comb input register are set to 0.
  - FSM goes to IDLE.
  - `out_data` = 0, `out_valid` = 0.
  - Reset mid-FSM aborts the sample; no `out_valid` for it.
- Transient: the first 4 output samples after reset or a stream change are filter-fill and are not checked for accuracy.

Optional Feature:
- Macro PDM_CIC_DCBLOCK_EN.
- Defined:
  - A first-order DC blocker runs in the OUT path on the saturated sample s[n]: y[n] = s[n] - s[n-1] + y[n-1] - (y[n-1] >>> 8).
  - 18-bit internal, saturated to OUT_BITS.
  - Adds one state (DCB) between C3 and OUT, so latency is 7 cycles.
  - DC blocker state is cleared by `rst`.
- Undefined: no DCB state, latency 6, out = saturated CIC output.

Test Plan:
- Constant `in_data`=1, `in_valid` every 32 clk, defaults -> from the 5th `out_valid` on, `out_data` = 32767 (saturated). Without DCBLOCK, constant thereafter.
- Constant `in_data`=0 -> from the 5th sample, `out_data` = -32768, steady.
- Alternating 1,0,1,0 -> from the 5th sample, `out_data` = 0 exactly. `out_valid` occurs once per 64 `in_valid`.
- Latency/strobe check -> `out_valid` exactly 6 clk after the 64th `in_valid` (7 with PDM_CIC_DCBLOCK_EN); `out_valid` width is 1 cycle.
- `sync` after 20 inputs -> next `out_valid` follows the 64th `in_valid` after `sync`. Integrator state is preserved: the all-ones stream still reads 32767 with no new transient.
- Assert `rst` during state C2 -> no `out_valid` for that frame; `out_data` = 0; restart gives an identical sequence to a cold start.
- With PDM_CIC_DCBLOCK_EN: constant 1 stream -> output magnitude decays monotonically toward 0 (below 64 within 2048 samples).
